// File: rtl/ev22_pkg.sv
// Shared ALU definitions: opcode encodings, datapath width and opcode
// classification helpers used by the register file and write-back stage.
package ev22_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ALUC_W = 4;

  localparam logic [ALUC_W-1:0] ALU_PASSA = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_PASSB = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_AND   = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [ALUC_W-1:0] ALU_ADD   = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_SUB   = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_XOR   = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_NOT   = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SHL   = 4'b1000;
  localparam logic [ALUC_W-1:0] ALU_SHR   = 4'b1001;
  localparam logic [ALUC_W-1:0] ALU_INC   = 4'b1010;
  localparam logic [ALUC_W-1:0] ALU_CLC   = 4'b1011;
  localparam logic [ALUC_W-1:0] ALU_SEC   = 4'b1100;

  // Opcodes whose commit modifies the carry flag.
  function automatic logic updates_carry(input logic [ALUC_W-1:0] aluc);
    return (aluc == ALU_ADD) || (aluc == ALU_SUB) ||
           (aluc == ALU_CLC) || (aluc == ALU_SEC);
  endfunction

  // Flag-only opcodes never write the register file.
  function automatic logic writes_reg(input logic [ALUC_W-1:0] aluc);
    return !((aluc == ALU_CLC) || (aluc == ALU_SEC));
  endfunction

  // Carry value an opcode commits; only meaningful when updates_carry() is set.
  function automatic logic carry_result(input logic [ALUC_W-1:0] aluc, input logic cy);
    logic res;
    res = cy;
    if (aluc == ALU_CLC) res = 1'b0;
    if (aluc == ALU_SEC) res = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Committed carry/zero flags plus the effective carry seen by the ALU,
// which forwards the carry of a pending write-back entry.
module alu_flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       pend_i,
  input  logic       commit_i,
  input  logic       reg_wr_i,
  input  logic [3:0] aluc_i,
  input  logic       cy_i,
  input  logic       z_zero_i,
  output logic       carry_flag_o,
  output logic       zero_flag_o,
  output logic       cy_eff_c_o
);
  import ev22_pkg::*;

  logic carry_q, carry_d;
  logic zero_q, zero_d;
  logic entry_cy_c;

  assign entry_cy_c = carry_result(aluc_i, cy_i);

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (commit_i) begin
      if (updates_carry(aluc_i)) carry_d = entry_cy_c;
      if (reg_wr_i)              zero_d  = z_zero_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Frozen entries still forward their carry while hold is asserted.
  assign cy_eff_c_o   = (pend_i && updates_carry(aluc_i)) ? entry_cy_c : carry_q;
  assign carry_flag_o = carry_q;
  assign zero_flag_o  = zero_q;

endmodule

// File: rtl/alu_regfile_wb.sv
// Register file and one-entry write-back stage around the ALU, with operand
// and carry forwarding from the pending entry so dependent ops never stall.
module alu_regfile_wb #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned NREG   = 8,
  localparam int unsigned SEL_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  rd_a_sel,
  input  logic [SEL_W-1:0]  rd_b_sel,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              cy_in,
  input  logic [DATA_W-1:0] z,
  input  logic              cy_out,
  input  logic [3:0]        aluc,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic              hold,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              wb_pending
);
  import ev22_pkg::*;

  logic [DATA_W-1:0] rf_q [NREG];

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_z_q,     wb_z_d;
  logic              wb_cy_q,    wb_cy_d;
  logic [3:0]        wb_aluc_q,  wb_aluc_d;
  logic [SEL_W-1:0]  wb_sel_q,   wb_sel_d;

  logic wb_write_c;
  logic commit_c;
  logic rf_we_c;
  logic fwd_a_c, fwd_b_c;

  // Write-back entry: load on capture, otherwise drain; hold freezes it.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_z_d     = wb_z_q;
    wb_cy_d    = wb_cy_q;
    wb_aluc_d  = wb_aluc_q;
    wb_sel_d   = wb_sel_q;
    if (!hold) begin
      wb_valid_d = wr_en;
      if (wr_en) begin
        wb_z_d    = z;
        wb_cy_d   = cy_out;
        wb_aluc_d = aluc;
        wb_sel_d  = wr_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_z_q     <= '0;
      wb_cy_q    <= 1'b0;
      wb_aluc_q  <= '0;
      wb_sel_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_z_q     <= wb_z_d;
      wb_cy_q    <= wb_cy_d;
      wb_aluc_q  <= wb_aluc_d;
      wb_sel_q   <= wb_sel_d;
    end
  end

  assign wb_write_c = writes_reg(wb_aluc_q);
  assign commit_c   = wb_valid_q && !hold;
  assign rf_we_c    = commit_c && wb_write_c && (wb_sel_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '{default: '0};
    end else if (rf_we_c) begin
      rf_q[wb_sel_q] <= wb_z_q;
    end
  end

  // R0 is hardwired to zero and never forwarded.
  assign fwd_a_c = wb_valid_q && wb_write_c && (wb_sel_q == rd_a_sel);
  assign fwd_b_c = wb_valid_q && wb_write_c && (wb_sel_q == rd_b_sel);

  assign a = (rd_a_sel == '0) ? '0 : (fwd_a_c ? wb_z_q : rf_q[rd_a_sel]);
  assign b = (rd_b_sel == '0) ? '0 : (fwd_b_c ? wb_z_q : rf_q[rd_b_sel]);

  alu_flag_reg u_flags (
    .clk          (clk),
    .rst          (rst),
    .pend_i       (wb_valid_q),
    .commit_i     (commit_c),
    .reg_wr_i     (rf_we_c),
    .aluc_i       (wb_aluc_q),
    .cy_i         (wb_cy_q),
    .z_zero_i     (wb_z_q == '0),
    .carry_flag_o (carry_flag),
    .zero_flag_o  (zero_flag),
    .cy_eff_c_o   (cy_in)
  );

  assign wb_pending = wb_valid_q;

endmodule

// File: doc/alu_regfile_wb.md
# alu_regfile_wb

Register file and write-back stage around the 16-bit ALU. It supplies the ALU operands `a`/`b` and the carry input `cy_in`. It captures the ALU result `z` and `cy_out` into a one-entry write-back register, then commits them to the register file and the carry/zero flags one cycle later. Forwarding from the pending write-back entry lets back-to-back dependent ALU operations run without stalls.

## Interface
- `DATA_W`, 16: datapath width; must match the ALU.
- `NREG`, 8: number of registers; `SEL_W = $clog2(NREG)`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rd_a_sel` in SEL_W: register driving `a`.
- `rd_b_sel` in SEL_W: register driving `b`.
- `a` out DATA_W: ALU operand A (combinational read with forwarding).
- `b` out DATA_W: ALU operand B (combinational read with forwarding).
- `cy_in` out 1: ALU carry input; the effective carry flag.
- `z` in DATA_W: ALU result.
- `cy_out` in 1: ALU carry result.
- `aluc` in 4: ALU opcode of the current operation.
- `wr_en` in 1: capture the current ALU result into write-back.
- `wr_sel` in SEL_W: destination register.
- `hold` in 1: freeze write-back capture and commit.
- `carry_flag` out 1: committed carry flag.
- `zero_flag` out 1: committed zero flag.
- `wb_pending` out 1: the write-back entry is valid.

## Operation
- **Capture.** On `wr_en=1 && hold=0` at edge N, the WB entry loads {`z`, `cy_out`, `aluc`, `wr_sel`} and sets `wb_valid=1`. Otherwise `wb_valid` clears at the edge, unless `hold=1`.
- **Commit.** At edge N+1, if `wb_valid && !hold`, the entry is committed.
  - Register write `rf[wb_sel] <= wb_z`, unless `wb_sel==0` or `wb_aluc` is 1011 or 1100 (flag-only ops).
  - Carry update:
    - 0100/0101: carry ← `wb_cy`.
    - 1011: carry ← 0.
    - 1100: carry ← 1.
    - All other opcodes: carry unchanged.
  - Zero update: `zero_flag` ← (`wb_z == 0`) only when the register write occurs.
- **R0.** Always reads 0. Writes to R0 are dropped, and R0 is never forwarded.
- **Operand read.** `a = (rd_a_sel==0) ? 0 : (wb_valid && wb_write && wb_sel==rd_a_sel) ? wb_z : rf[rd_a_sel]`. `b` follows the same rule with `rd_b_sel`.
- **Carry read.** `cy_in` = the carry the pending entry would commit if `wb_valid` and the entry updates carry; otherwise `carry_flag`.
- **Capture and commit in the same edge.** The older entry commits while the new one loads. Back-to-back operations to the same register resolve to the newer value through forwarding.
- **Hold.** `hold=1` freezes the WB entry, the register file and the flags. Forwarding stays active from the frozen entry.

## Timing
- **Reset.** Reset values: all `rf` = 0, `wb_valid`=0, `wb_pending`=0, `carry_flag`=0, `zero_flag`=0, `a`=`b`=0, `cy_in`=0.
  - Reset during a pending entry discards it; no commit occurs.
  - Reset has priority over `hold` and `wr_en`.
- **Latency.**
  - Result captured at edge N is visible on `a`/`b` (forwarded) immediately after edge N.
  - It is visible in `rf` and flags after edge N+1.
  - Each additional `hold` cycle delays the commit by 1.
- **Throughput.** One ALU operation per cycle; no bubbles are required.
- `wb_pending` equals `wb_valid` (registered).
- `a`, `b`, `cy_in` are combinational from the selects and state. There is no combinational path from `z` to `a`/`b`.

## Structure
- **Shared package** `ev22_pkg`:
  - `aluc` opcode constants (`ALU_PASSA`=0000 … `ALU_CLC`=1011, `ALU_SEC`=1100).
  - `DATA_W`.
  - Function `updates_carry(aluc)`.
  - Function `writes_reg(aluc)`.
- **Sub-module** `alu_flag_reg`: carry and zero flag registers with commit logic and carry forwarding.
- **Top level:** register array, WB entry, read muxes.

## Test plan
- **Reset.** Assert `rst` with `wr_en=1`, `z`=16'h1234 → all outputs 0 and `rf` all 0 after release.
- **Forward then commit.** Capture `z`=16'hBEEF, `wr_sel`=3, `aluc`=0100, `cy_out`=1.
  - Next cycle with `rd_a_sel`=3 → `a`=16'hBEEF and `cy_in`=1.
  - One edge later → `rf[3]`=16'hBEEF, `carry_flag`=1, `zero_flag`=0.
- **Flag-only ops.** Issue `aluc`=1100 with `wr_sel`=2, `z`=16'h5555 → `rf[2]` unchanged and `carry_flag`=1. Then issue 1011 → `carry_flag`=0.
- **R0 and zero flag.** Write 16'h00FF to R0 → R0 reads 0 and `zero_flag` unchanged. Write 16'h0000 to R5 → `zero_flag`=1.
- **Back-to-back.** Write R1=16'h0001, then R1=16'h0002 on consecutive cycles → `a` (R1) reads 0001, then 0002; final `rf[1]`=16'h0002.
- **Hold and mid-operation reset.** Capture R4=16'hCAFE and hold for 3 cycles → `rf[4]` is unchanged while held and `a`(R4)=CAFE throughout. Assert `rst` during the hold → `rf[4]`=0 and `wb_pending`=0.
